// File: rtl/eth_pcs_rx_block_sync.sv
// 64b/66b PCS receive block-lock engine: tests sync headers and slips the gearbox.
// Optional statistics counters are enabled by `ETH_PCS_RX_BSYNC_STATS_EN.
`timescale 1ns/1ps

package eth_pcs_rx_block_sync_pkg;
    localparam int W_SYNC        = 2;
    localparam int W_SH_VAL_TH   = 7;
    localparam int W_SH_INVAL_TH = 5;

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;
endpackage

module eth_pcs_rx_block_sync
    import eth_pcs_rx_block_sync_pkg::*;
#(
    parameter int SH_VAL_TH   = 64,
    parameter int SH_INVAL_TH = 16,
    parameter int SLIP_WAIT   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sh_valid,
    input  logic [W_SYNC-1:0] i_sh,
    output logic              o_slip,
    output logic              o_block_lock,
    output logic              o_sh_err
`ifdef ETH_PCS_RX_BSYNC_STATS_EN
    ,
    output logic [15:0]       o_inval_cnt,
    output logic [15:0]       o_lock_loss_cnt
`endif
);

    localparam int W_WAIT = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [W_SH_VAL_TH-1:0] VAL_LAST =
        W_SH_VAL_TH'(SH_VAL_TH - 1);
    localparam logic [W_SH_INVAL_TH-1:0] INV_LAST =
        W_SH_INVAL_TH'(SH_INVAL_TH - 1);
    localparam logic [W_WAIT-1:0] WAIT_LAST =
        W_WAIT'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_RESET_CNT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP      = 2'd2,
        ST_SLIP_WAIT = 2'd3
    } lock_state_e;

    lock_state_e              state_q, state_d;
    logic [W_SH_VAL_TH-1:0]   sh_cnt_q, sh_cnt_d;
    logic [W_SH_INVAL_TH-1:0] inv_cnt_q, inv_cnt_d;
    logic [W_WAIT-1:0]        wait_cnt_q, wait_cnt_d;
    logic                     slip_q, slip_d;
    logic                     lock_q, lock_d;
    logic                     err_q, err_d;

    logic sh_ok;
    logic sh_bad;

    // Header classification: only 01 and 10 are legal sync headers.
    always_comb begin
        sh_ok  = (i_sh == SYNC_DATA) || (i_sh == SYNC_CTRL);
        sh_bad = i_sh_valid && !sh_ok;
    end

    // State, window counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_RESET_CNT;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            slip_q     <= 1'b0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            slip_q     <= slip_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
        end
    end

    // Lock FSM: next state, counter updates and next output values.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        slip_d     = 1'b0;
        lock_d     = lock_q;
        err_d      = 1'b0;

        unique case (state_q)
            ST_RESET_CNT: begin
                sh_cnt_d  = '0;
                inv_cnt_d = '0;
                state_d   = ST_TEST_SH;
            end

            ST_TEST_SH: begin
                if (i_sh_valid) begin
                    sh_cnt_d  = sh_cnt_q + W_SH_VAL_TH'(1);
                    inv_cnt_d = inv_cnt_q + W_SH_INVAL_TH'(sh_bad);
                    err_d     = sh_bad;
                    // A slip outranks the end-of-window decision.
                    if (sh_bad && (!lock_q || inv_cnt_q == INV_LAST)) begin
                        state_d = ST_SLIP;
                        slip_d  = 1'b1;
                        lock_d  = 1'b0;
                    end else if (sh_cnt_q == VAL_LAST) begin
                        state_d = ST_RESET_CNT;
                        // A window with no bad header grants lock;
                        // otherwise lock is simply held.
                        if (inv_cnt_q == '0 && !sh_bad) begin
                            lock_d = 1'b1;
                        end
                    end
                end
            end

            ST_SLIP: begin
                lock_d     = 1'b0;
                wait_cnt_d = '0;
                state_d    = ST_SLIP_WAIT;
            end

            ST_SLIP_WAIT: begin
                // Headers here come from a realigning gearbox; skip them.
                if (i_sh_valid) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ST_RESET_CNT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + W_WAIT'(1);
                    end
                end
            end

            default: begin
                state_d = ST_RESET_CNT;
            end
        endcase
    end

    assign o_slip       = slip_q;
    assign o_block_lock = lock_q;
    assign o_sh_err     = err_q;

`ifdef ETH_PCS_RX_BSYNC_STATS_EN
    logic [15:0] inval_cnt_q, inval_cnt_d;
    logic [15:0] lock_loss_cnt_q, lock_loss_cnt_d;

    // Saturating statistics: bad headers in any state, lock losses.
    always_comb begin
        inval_cnt_d     = inval_cnt_q;
        lock_loss_cnt_d = lock_loss_cnt_q;
        if (sh_bad && inval_cnt_q != 16'hFFFF) begin
            inval_cnt_d = inval_cnt_q + 16'd1;
        end
        if (lock_q && !lock_d && lock_loss_cnt_q != 16'hFFFF) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inval_cnt_q     <= '0;
            lock_loss_cnt_q <= '0;
        end else begin
            inval_cnt_q     <= inval_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
        end
    end

    assign o_inval_cnt     = inval_cnt_q;
    assign o_lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_eth_pcs_rx_block_sync.sv
// Self-checking bench for the 64b/66b receive block-lock engine.
// Vector tables feed a scoreboard queue; a gearbox model covers slipping.
`timescale 1ns/1ps

module tb_eth_pcs_rx_block_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sh_valid;
    logic [1:0] sh;
    logic       o_slip;
    logic       o_block_lock;
    logic       o_sh_err;
`ifdef ETH_PCS_RX_BSYNC_STATS_EN
    logic [15:0] o_inval_cnt;
    logic [15:0] o_lock_loss_cnt;
`endif

    eth_pcs_rx_block_sync dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sh_valid     (sh_valid),
        .i_sh           (sh),
        .o_slip         (o_slip),
        .o_block_lock   (o_block_lock),
        .o_sh_err       (o_sh_err)
`ifdef ETH_PCS_RX_BSYNC_STATS_EN
        ,
        .o_inval_cnt    (o_inval_cnt),
        .o_lock_loss_cnt(o_lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sh;
        logic       slip;
        logic       lock;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [65:0] blk [0:511];

    function automatic logic [1:0] good(input int i);
        return (i % 2 == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] bad(input int i);
        return (i % 2 == 1) ? 2'b11 : 2'b00;
    endfunction

    task automatic cmp3(input string nm, input logic [2:0] act,
                        input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s slip/lock/err got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cmp_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] s, input logic sl,
                       input logic lk, input logic er);
        vec_t v;
        v.sh = s; v.slip = sl; v.lock = lk; v.err = er;
        vecs.push_back(v);
    endtask

    // Drive one cycle and compare against the oldest scoreboard entry.
    task automatic step(input logic v, input logic [1:0] s,
                        input string nm);
        vec_t e;
        @(negedge clk);
        sh_valid = v;
        sh       = s;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            cmp3(nm, {o_slip, o_block_lock, o_sh_err},
                 {e.slip, e.lock, e.err});
        end
    endtask

    task automatic idle(input int n, input logic lk, input string nm);
        vec_t e;
        for (int i = 0; i < n; i++) begin
            e.sh = 2'b00; e.slip = 1'b0; e.lock = lk; e.err = 1'b0;
            exp_q.push_back(e);
            step(1'b0, 2'b11, nm);
        end
    endtask

    // Apply the vector table; with gaps each strobe is followed by an idle.
    task automatic run_vecs(input string nm, input bit b2b);
        vec_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back(vecs[i]);
            step(1'b1, vecs[i].sh, nm);
            if (!b2b) begin
                e.sh = 2'b00; e.slip = 1'b0;
                e.lock = vecs[i].lock; e.err = 1'b0;
                exp_q.push_back(e);
                step(1'b0, 2'b00, {nm, "_gap"});
            end
        end
        vecs.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        sh_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        cmp3("reset_out", {o_slip, o_block_lock, o_sh_err}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 1'b0, "post_reset");
    endtask

    function automatic logic stream_bit(input int p);
        return blk[p / 66][65 - (p % 66)];
    endfunction

    int slips;
    int off;
    int k;
    bit locked;

    initial begin
        rst_n    = 1'b0;
        sh_valid = 1'b0;
        sh       = 2'b00;

        // Reset state and first lock from a clean window.
        do_reset();
        for (int i = 0; i < 64; i++) add(good(i), 1'b0, i == 63, 1'b0);
        run_vecs("lock_acq", 1'b0);

        // Locked: 15 bad headers in a window keep lock.
        for (int i = 0; i < 64; i++) begin
            if (i < 15) add(bad(i), 1'b0, 1'b1, 1'b1);
            else        add(good(i), 1'b0, 1'b1, 1'b0);
        end
        run_vecs("inval15", 1'b0);
        for (int i = 0; i < 64; i++) add(good(i), 1'b0, 1'b1, 1'b0);
        run_vecs("keep_lock", 1'b0);

        // Locked: the 16th bad header drops lock and slips.
        for (int i = 0; i < 16; i++) add(bad(i), i == 15, i != 15, 1'b1);
        for (int i = 0; i < 4; i++) add(bad(i), 1'b0, 1'b0, 1'b0);
        run_vecs("inval16", 1'b0);
`ifdef ETH_PCS_RX_BSYNC_STATS_EN
        cmp_int("lock_loss_cnt", int'(o_lock_loss_cnt), 1);
`endif
        for (int i = 0; i < 64; i++) add(good(i), 1'b0, i == 63, 1'b0);
        run_vecs("relock", 1'b0);

        // Async reset mid-window while locked.
        for (int i = 0; i < 10; i++) add(good(i), 1'b0, 1'b1, 1'b0);
        run_vecs("b2b_locked", 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        cmp3("rst_async", {o_slip, o_block_lock, o_sh_err}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1, 1'b0, "rst_release");
        for (int i = 0; i < 20; i++) add(good(i), 1'b0, 1'b0, 1'b0);
        run_vecs("b2b_unlocked", 1'b1);
        for (int i = 20; i < 64; i++) add(good(i), 1'b0, i == 63, 1'b0);
        run_vecs("relock_after_rst", 1'b0);

        // Unlocked: 5th header 11 slips, next four are ignored.
        do_reset();
        for (int i = 0; i < 4; i++) add(good(i), 1'b0, 1'b0, 1'b0);
        add(2'b11, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) add(2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) add(good(i), 1'b0, i == 63, 1'b0);
        run_vecs("unlocked_slip", 1'b0);

        // Gearbox model: stream starts three bits early.
        do_reset();
        for (int b = 0; b < 512; b++) begin
            blk[b] = {good(int'($urandom_range(0, 1))), $urandom, $urandom};
        end
        slips  = 0;
        off    = 63;
        locked = 1'b0;
        k      = 0;
        while (!locked && k < 400) begin
            @(negedge clk);
            sh_valid = 1'b1;
            sh = {stream_bit(k * 66 + off), stream_bit(k * 66 + off + 1)};
            @(posedge clk);
            #1;
            if (o_slip) begin
                slips++;
                off = (off + 1) % 66;
            end
            locked = o_block_lock;
            k++;
            @(negedge clk);
            sh_valid = 1'b0;
            @(posedge clk);
        end
        cmp_int("gbx_locked", int'(locked), 1);
        cmp_int("gbx_slips", slips, 3);
        cmp_int("gbx_offset", off, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
